// File: rtl/oled_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package     : oled_pkg                                              |
// | Description : Display geometry, RGB565 colours and the index-step   |
// |               encoding shared by the OLED shape cycler.             |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
package oled_pkg;

  localparam int DISP_W = 96;
  localparam int DISP_H = 64;
  localparam int PIX_W  = 13;

  localparam logic [15:0] COL_BLACK  = 16'h0000;
  localparam logic [15:0] COL_RED    = 16'hF800;
  localparam logic [15:0] COL_GREEN  = 16'h07E0;
  localparam logic [15:0] COL_ORANGE = 16'hFC00;
  localparam logic [15:0] COL_WHITE  = 16'hFFFF;

  // Direction the shape index takes on a given cycle.
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_e;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : btn_debounce                                          |
// | Description : Two-flop synchroniser, tick-based debounce and a      |
// |               one-cycle pulse on each accepted press.               |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
module btn_debounce
  import oled_pkg::*;
#(
  parameter int DEB_MS = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick_en,
  input  logic i_btn,
  output logic o_press
);

  localparam int c_CNT_W = $clog2(DEB_MS + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_MS - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_stable;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_accept;

  // A new level is taken on the tick where it has differed for DEB_MS ticks.
  assign w_accept = i_tick_en && (r_sync2 != r_stable) && (r_cnt == c_CNT_LAST);
  // The press pulse coincides with the stable level rising, so the index can move on that same edge.
  assign o_press  = w_accept && r_sync2;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive differing ticks; any agreeing tick restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (i_tick_en) begin
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/oled_shape_cycler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : oled_shape_cycler                                     |
// | Description : Button/auto driven shape index plus a two-stage       |
// |               border / window / ring pixel compositor.              |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
module oled_shape_cycler #(
  parameter int DISP_W     = oled_pkg::DISP_W,
  parameter int DISP_H     = oled_pkg::DISP_H,
  parameter int PIX_W      = oled_pkg::PIX_W,
  parameter int NUM_SHAPES = 7,
  parameter int SEL_W      = 3,
  parameter int TICK_DIV   = 25000,
  parameter int DEB_MS     = 200,
  parameter int AUTO_MS    = 1000,
  parameter int BORDER     = 7,
  parameter int WIN_X0     = 40,
  parameter int WIN_X1     = 56,
  parameter int WIN_Y0     = 24,
  parameter int WIN_Y1     = 40,
  parameter int RING_SPLIT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_btn_up,
  input  logic                     i_btn_down,
  input  logic                     i_auto_en,
  input  logic [PIX_W-1:0]         i_pixel_index,
  input  logic [16*NUM_SHAPES-1:0] i_shape_colors,
  input  logic [15:0]              i_border_color,
  input  logic [15:0]              i_ring_a_color,
  input  logic [15:0]              i_ring_b_color,
  output logic [SEL_W-1:0]         o_sel_idx,
  output logic                     o_press_pulse,
  output logic [15:0]              o_color_out
);

  import oled_pkg::*;

  localparam int c_X_W    = $clog2(DISP_W);
  localparam int c_Y_W    = $clog2(DISP_H);
  localparam int c_TICK_W = $clog2(TICK_DIV + 1);
  localparam int c_AUTO_W = $clog2(AUTO_MS + 1);

  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
  localparam logic [c_AUTO_W-1:0] c_AUTO_LAST = c_AUTO_W'(AUTO_MS - 1);
  localparam logic [SEL_W-1:0]    c_SEL_LAST  = SEL_W'(NUM_SHAPES - 1);
  localparam logic [SEL_W-1:0]    c_SPLIT     = SEL_W'(RING_SPLIT);
  localparam logic [PIX_W-1:0]    c_PIX_W_DIV = PIX_W'(DISP_W);
  localparam logic [PIX_W-1:0]    c_PIX_H_LIM = PIX_W'(DISP_H);
  localparam logic [c_X_W-1:0]    c_BX_LO     = c_X_W'(BORDER);
  localparam logic [c_X_W-1:0]    c_BX_HI     = c_X_W'(DISP_W - BORDER);
  localparam logic [c_Y_W-1:0]    c_BY_LO     = c_Y_W'(BORDER);
  localparam logic [c_Y_W-1:0]    c_BY_HI     = c_Y_W'(DISP_H - BORDER);
  localparam logic [c_X_W-1:0]    c_WX0       = c_X_W'(WIN_X0);
  localparam logic [c_X_W-1:0]    c_WX1       = c_X_W'(WIN_X1);
  localparam logic [c_Y_W-1:0]    c_WY0       = c_Y_W'(WIN_Y0);
  localparam logic [c_Y_W-1:0]    c_WY1       = c_Y_W'(WIN_Y1);

  logic [c_TICK_W-1:0] r_tick_cnt;
  logic [c_AUTO_W-1:0] r_auto_cnt;
  logic [SEL_W-1:0]    r_sel;
  logic                r_pulse;
  logic                w_tick_en;
  logic                w_up_press;
  logic                w_dn_press;
  step_e               w_step;
  logic [SEL_W-1:0]    w_sel_next;

  logic [c_X_W-1:0]    r_x;
  logic [c_Y_W-1:0]    r_y;
  logic                r_p_valid;
  logic [SEL_W-1:0]    r_p_sel;
  logic [PIX_W-1:0]    w_row;
  logic                w_border;
  logic                w_window;
  logic [15:0]         w_color;
  logic [15:0]         r_color;

  assign o_sel_idx     = r_sel;
  assign o_press_pulse = r_pulse;
  assign o_color_out   = r_color;

  // 1 ms time base shared by both debouncers and the auto-advance counter.
  assign w_tick_en = (r_tick_cnt == c_TICK_LAST);

  // Free-running tick divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_tick_cnt <= '0;
    else if (w_tick_en) r_tick_cnt <= '0;
    else                r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  btn_debounce #(.DEB_MS(DEB_MS)) u_deb_up (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_tick_en (w_tick_en),
    .i_btn     (i_btn_up),
    .o_press   (w_up_press)
  );

  btn_debounce #(.DEB_MS(DEB_MS)) u_deb_dn (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_tick_en (w_tick_en),
    .i_btn     (i_btn_down),
    .o_press   (w_dn_press)
  );

  // Pick this cycle's step: simultaneous presses cancel, manual beats auto.
  always_comb begin
    w_step = STEP_NONE;
    if (w_up_press && w_dn_press)                                  w_step = STEP_NONE;
    else if (w_up_press)                                           w_step = STEP_UP;
    else if (w_dn_press)                                           w_step = STEP_DOWN;
    else if (i_auto_en && w_tick_en && (r_auto_cnt == c_AUTO_LAST)) w_step = STEP_UP;
  end

  // Wrap the index inside 0..NUM_SHAPES-1 in both directions.
  always_comb begin
    w_sel_next = r_sel;
    case (w_step)
      STEP_UP:   w_sel_next = (r_sel == c_SEL_LAST) ? '0 : r_sel + 1'b1;
      STEP_DOWN: w_sel_next = (r_sel == '0) ? c_SEL_LAST : r_sel - 1'b1;
      default:   w_sel_next = r_sel;
    endcase
  end

  // Index register and its step pulse move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sel   <= w_sel_next;
      r_pulse <= (w_step != STEP_NONE);
    end
  end

  // Auto-advance interval counter; a manual press restarts the interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_auto_cnt <= '0;
    else if (!i_auto_en || w_up_press || w_dn_press) r_auto_cnt <= '0;
    else if (w_tick_en)
      r_auto_cnt <= (r_auto_cnt == c_AUTO_LAST) ? '0 : r_auto_cnt + 1'b1;
  end

  // Row number; comparing it against the height doubles as the in-range test.
  assign w_row = i_pixel_index / c_PIX_W_DIV;

  // Stage 1: split the index into x/y and freeze the shape index for this pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_y       <= '0;
      r_p_valid <= 1'b0;
      r_p_sel   <= '0;
    end else begin
      r_x       <= c_X_W'(i_pixel_index % c_PIX_W_DIV);
      r_y       <= c_Y_W'(w_row);
      r_p_valid <= (w_row < c_PIX_H_LIM);
      r_p_sel   <= r_sel;
    end
  end

  // Stage 2 region decode: off-screen, then border, then window, then ring.
  always_comb begin
    w_border = (r_x < c_BX_LO) || (r_x >= c_BX_HI) || (r_y < c_BY_LO) || (r_y >= c_BY_HI);
    w_window = (r_x >= c_WX0) && (r_x <= c_WX1) && (r_y >= c_WY0) && (r_y <= c_WY1);
    w_color  = COL_BLACK;
    if (!r_p_valid)            w_color = COL_BLACK;
    else if (w_border)         w_color = i_border_color;
    else if (w_window)         w_color = (r_p_sel == '0) ? COL_BLACK
                                                         : i_shape_colors[{r_p_sel, 4'b0000} +: 16];
    else if (r_p_sel < c_SPLIT) w_color = i_ring_a_color;
    else                       w_color = i_ring_b_color;
  end

  // Stage 2 output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_color <= '0;
    else        r_color <= w_color;
  end

endmodule
`default_nettype wire

// File: tb/tb_oled_shape_cycler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_oled_shape_cycler                                  |
// | Description : Directed bench with index and pixel scoreboards.      |
// | Revision    : 1.0 - initial release                                 |
// +--------------------------------------------------------------------+
module tb_oled_shape_cycler;
  import oled_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         btn_up = 1'b0;
  logic         btn_down = 1'b0;
  logic         auto_en = 1'b0;
  logic [12:0]  pixel_index = '0;
  logic [111:0] shape_colors;
  logic [15:0]  border_color = COL_WHITE;
  logic [15:0]  ring_a_color = COL_GREEN;
  logic [15:0]  ring_b_color = COL_ORANGE;
  logic [2:0]   sel_idx;
  logic         press_pulse;
  logic [15:0]  color_out;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int exp_sel = 0;
  int pulse_cyc[$];
  logic [2:0]  sel_q[$];
  logic [15:0] col_q[$];
  int pix_list[$];

  oled_shape_cycler #(
    .TICK_DIV (10),
    .DEB_MS   (3),
    .AUTO_MS  (5)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_btn_up       (btn_up),
    .i_btn_down     (btn_down),
    .i_auto_en      (auto_en),
    .i_pixel_index  (pixel_index),
    .i_shape_colors (shape_colors),
    .i_border_color (border_color),
    .i_ring_a_color (ring_a_color),
    .i_ring_b_color (ring_b_color),
    .o_sel_idx      (sel_idx),
    .o_press_pulse  (press_pulse),
    .o_color_out    (color_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] shp_col(input int k);
    return (k == 0) ? 16'hBEEF : 16'(16'h1000 + k * 16'h0123);
  endfunction

  // Reference compositor written from the display geometry.
  function automatic logic [15:0] model(input int idx, input int sel);
    int x = idx % 96;
    int y = idx / 96;
    if (idx >= 6144) return 16'h0000;
    if (x < 7 || x >= 89 || y < 7 || y >= 57) return border_color;
    if (x >= 40 && x <= 56 && y >= 24 && y <= 40) return (sel == 0) ? 16'h0000 : shp_col(sel);
    return (sel < 4) ? ring_a_color : ring_b_color;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each step pulse must have been announced, and sel must already hold the new value.
  always @(negedge clk) begin
    if (rst_n && press_pulse) begin
      logic [2:0] e;
      pulse_cnt++;
      pulse_cyc.push_back(cyc);
      chk("pulse_expected", 32'(sel_q.size() != 0), 32'd1);
      if (sel_q.size() != 0) begin
        e = sel_q.pop_front();
        chk("sel_at_pulse", 32'(sel_idx), 32'(e));
      end
    end
  end

  task automatic exp_step(input int dir);
    logic [31:0] t;
    if (dir > 0) exp_sel = (exp_sel == 6) ? 0 : exp_sel + 1;
    else         exp_sel = (exp_sel == 0) ? 6 : exp_sel - 1;
    t = 32'(exp_sel);
    sel_q.push_back(t[2:0]);
  endtask

  task automatic press(input logic up, input logic dn);
    @(negedge clk);
    btn_up = up;
    btn_down = dn;
    repeat (50) @(negedge clk);
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (50) @(negedge clk);
  endtask

  task automatic wait_pulses(input int n, input int bound);
    int start = pulse_cnt;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if (pulse_cnt >= start + n) break;
    end
    chk("pulse_wait", 32'(pulse_cnt >= start + n), 32'd1);
  endtask

  task automatic run_pix();
    int n = pix_list.size();
    logic [15:0] e;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = col_q.pop_front();
        chk("pixel", 32'(color_out), 32'(e));
      end
      if (i < n) begin
        pixel_index = 13'(pix_list[i]);
        col_q.push_back(model(pix_list[i], exp_sel));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int m;
    for (int k = 0; k < 7; k++) shape_colors[16*k +: 16] = shp_col(k);

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_sel", 32'(sel_idx), 32'd0);
    chk("reset_pulse", 32'(press_pulse), 32'd0);
    chk("reset_color", 32'(color_out), 32'd0);

    // Bouncing up button yields a single accepted press
    p0 = pulse_cnt;
    exp_step(1);
    repeat (4) begin
      btn_up = ~btn_up;
      repeat (5) @(negedge clk);
    end
    btn_up = 1'b1;
    repeat (40) @(negedge clk);
    btn_up = 1'b0;
    repeat (60) @(negedge clk);
    chk("bounce_pulses", 32'(pulse_cnt - p0), 32'd1);
    chk("bounce_sel", 32'(sel_idx), 32'd1);

    // Walk up to 6, wrap up to 0, wrap down to 6
    for (int i = 0; i < 5; i++) begin
      exp_step(1);
      press(1'b1, 1'b0);
    end
    chk("sel_six", 32'(sel_idx), 32'd6);
    exp_step(1);
    press(1'b1, 1'b0);
    chk("wrap_up", 32'(sel_idx), 32'd0);
    exp_step(-1);
    press(1'b0, 1'b1);
    chk("wrap_down", 32'(sel_idx), 32'd6);

    // Both buttons together cancel
    p0 = pulse_cnt;
    press(1'b1, 1'b1);
    chk("both_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    chk("both_sel", 32'(sel_idx), 32'd6);

    // Auto-advance every 50 clocks
    exp_step(1);
    exp_step(1);
    exp_step(1);
    @(negedge clk);
    auto_en = 1'b1;
    wait_pulses(3, 300);
    chk("auto_period", 32'(pulse_cyc[pulse_cyc.size()-1] - pulse_cyc[pulse_cyc.size()-2]), 32'd50);

    // Manual press restarts the auto interval
    repeat (5) @(negedge clk);
    btn_up = 1'b1;
    exp_step(1);
    exp_step(1);
    wait_pulses(1, 100);
    m = pulse_cyc[pulse_cyc.size()-1];
    btn_up = 1'b0;
    wait_pulses(1, 100);
    chk("auto_after_manual", 32'(pulse_cyc[pulse_cyc.size()-1] - m), 32'd50);
    @(negedge clk);
    auto_en = 1'b0;
    p0 = pulse_cnt;
    repeat (120) @(negedge clk);
    chk("auto_off_pulses", 32'(pulse_cnt - p0), 32'd0);
    chk("auto_off_sel", 32'(sel_idx), 32'd4);

    // Pixels with sel = 2
    exp_step(-1);
    press(1'b0, 1'b1);
    exp_step(-1);
    press(1'b0, 1'b1);
    chk("sel_two", 32'(sel_idx), 32'd2);
    pix_list = '{0, 3120, 1940, 6144, 1049, 1048, 2344, 3896, 3897, 5492, 5396, 6143, 8191, 0};
    run_pix();

    // Ring split at sel = 4
    exp_step(1);
    press(1'b1, 1'b0);
    exp_step(1);
    press(1'b1, 1'b0);
    chk("sel_four", 32'(sel_idx), 32'd4);
    pix_list = '{1940, 3120, 0, 1048, 3120};
    run_pix();

    // Blank window at sel = 0
    for (int i = 0; i < 3; i++) begin
      exp_step(1);
      press(1'b1, 1'b0);
    end
    chk("sel_zero", 32'(sel_idx), 32'd0);
    pix_list = '{3120, 1940, 2344, 0, 3120};
    run_pix();

    // Asynchronous reset mid-run
    exp_step(1);
    press(1'b1, 1'b0);
    pixel_index = 13'd0;
    repeat (3) @(negedge clk);
    chk("pre_reset_color", 32'(color_out), 32'(border_color));
    #2;
    rst_n = 1'b0;
    exp_sel = 0;
    #1;
    chk("async_reset_sel", 32'(sel_idx), 32'd0);
    chk("async_reset_color", 32'(color_out), 32'd0);
    chk("async_reset_pulse", 32'(press_pulse), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_1cyc", 32'(color_out), 32'd0);
    @(negedge clk);
    chk("post_reset_2cyc", 32'(color_out), 32'(border_color));
    chk("sel_queue_drained", 32'(sel_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
